ccm_lsu_port: RTL and testbench

CCM_LSU_PORT -- requirements
Module: ccm_lsu_port

---
 rtl/ccm_lsu_port_if.sv | 26 ++
 rtl/ccm_lsu_port.sv | 132 +++++++++++++
 tb/tb_ccm_lsu_port.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ccm_lsu_port_if.sv
// Core-side load/store request and completion bus of the CCM LSU port.
// master = core (issues requests), slave = LSU port (accepts and completes them).
interface ccm_lsu_port_if #(
    parameter int ADDR_WIDTH = 11,
    parameter int DATA_WIDTH = 32
);
    logic                    req_valid;
    logic                    req_ready;
    logic                    req_we;
    logic [ADDR_WIDTH-1:0]   req_addr;
    logic [DATA_WIDTH-1:0]   req_wdata;
    logic [DATA_WIDTH/8-1:0] req_be;
    logic                    resp_valid;
    logic [DATA_WIDTH-1:0]   resp_rdata;
    logic                    resp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_be,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_be,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/ccm_lsu_port.sv
// Single-outstanding load/store port onto the CCM controller; partial stores
// are done as read-modify-write, read returns are bounded by a timeout.
//
// Handshake: a request transfers on a rising edge where req_valid & req_ready;
// req_ready is high only while idle. resp_valid is a one-cycle pulse that the
// core must take (no backpressure); resp_rdata/resp_err are valid with it.
module ccm_lsu_port #(
    parameter int ADDR_WIDTH = 11,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    ccm_lsu_port_if.slave         bus,
    output logic                  cntlr_rd,
    output logic [ADDR_WIDTH-1:0] cntlr_raddr,
    input  logic [DATA_WIDTH-1:0] cntlr_rd_data,
    input  logic                  cntlr_rd_valid,
    output logic                  cntlr_wr,
    output logic [ADDR_WIDTH-1:0] cntlr_waddr,
    output logic [DATA_WIDTH-1:0] cntlr_wr_data,
    output logic [2:0]            state_dbg
);
    localparam int BE_W = DATA_WIDTH / 8;
    localparam int CW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] RD_ISSUE = 3'd1;
    localparam logic [2:0] RD_WAIT  = 3'd2;
    localparam logic [2:0] WR_ISSUE = 3'd3;
    localparam logic [2:0] RESP     = 3'd4;

    logic [2:0]            state, state_d;
    logic                  ready_q;
    logic [CW-1:0]         cnt;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [BE_W-1:0]       be_q;
    logic                  we_q;
    logic [DATA_WIDTH-1:0] wbuf;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  err_q;
    logic [DATA_WIDTH-1:0] merged;
    logic                  accept;

    // ready_q mirrors state==IDLE but stays low through reset and is registered,
    // so req_ready has no path from rst or any other input.
    assign accept = ready_q & bus.req_valid;

    always_comb begin
        for (int i = 0; i < BE_W; i++) begin
            merged[8*i +: 8] = be_q[i] ? wdata_q[8*i +: 8] : cntlr_rd_data[8*i +: 8];
        end
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (bus.req_we && bus.req_be == '0)      state_d = RESP;
                    else if (bus.req_we && bus.req_be == '1) state_d = WR_ISSUE;
                    else                                     state_d = RD_ISSUE;
                end
            end
            RD_ISSUE: state_d = RD_WAIT;
            RD_WAIT: begin
                if (cntlr_rd_valid)       state_d = we_q ? WR_ISSUE : RESP;
                else if (cnt == CNT_LAST) state_d = RESP;
            end
            WR_ISSUE: state_d = RESP;
            RESP:     state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            ready_q <= 1'b0;
            cnt     <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            we_q    <= 1'b0;
            wbuf    <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state   <= state_d;
            ready_q <= (state_d == IDLE);
            case (state)
                IDLE: begin
                    if (accept) begin
                        addr_q  <= bus.req_addr;
                        wdata_q <= bus.req_wdata;
                        be_q    <= bus.req_be;
                        we_q    <= bus.req_we;
                        wbuf    <= bus.req_wdata;
                        rdata_q <= '0;
                        err_q   <= 1'b0;
                    end
                end
                RD_ISSUE: cnt <= '0;
                RD_WAIT: begin
                    if (cntlr_rd_valid) begin
                        if (we_q) wbuf    <= merged;
                        else      rdata_q <= cntlr_rd_data;
                    end else if (cnt == CNT_LAST) begin
                        err_q   <= 1'b1;
                        rdata_q <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.req_ready  = ready_q;
    assign bus.resp_valid = (state == RESP);
    assign bus.resp_rdata = rdata_q;
    assign bus.resp_err   = err_q;
    assign cntlr_rd       = (state == RD_ISSUE);
    assign cntlr_raddr    = addr_q;
    assign cntlr_wr       = (state == WR_ISSUE);
    assign cntlr_waddr    = addr_q;
    assign cntlr_wr_data  = wbuf;
    assign state_dbg      = state;
endmodule

// File: tb/tb_ccm_lsu_port.sv
// Directed bench for ccm_lsu_port: a one-cycle-latency memory model on the
// controller side, per-scenario tasks with inline checks of timing and data.
module tb_ccm_lsu_port;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cntlr_rd, cntlr_wr, cntlr_rd_valid;
  logic [10:0] cntlr_raddr, cntlr_waddr;
  logic [31:0] cntlr_rd_data, cntlr_wr_data;
  logic [2:0]  state_dbg;

  ccm_lsu_port_if #(.ADDR_WIDTH(11), .DATA_WIDTH(32)) bus ();

  ccm_lsu_port #(.ADDR_WIDTH(11), .DATA_WIDTH(32), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .cntlr_rd(cntlr_rd), .cntlr_raddr(cntlr_raddr),
    .cntlr_rd_data(cntlr_rd_data), .cntlr_rd_valid(cntlr_rd_valid),
    .cntlr_wr(cntlr_wr), .cntlr_waddr(cntlr_waddr), .cntlr_wr_data(cntlr_wr_data),
    .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // memory model: returns data one cycle after cntlr_rd; preload port for the bench
  logic [31:0] mem [0:2047];
  logic        mem_en = 1'b1;
  logic        late_valid = 1'b0;
  logic        model_valid;
  logic [31:0] model_data;
  logic        pre_we = 1'b0;
  logic [10:0] pre_addr = '0;
  logic [31:0] pre_data = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      model_valid <= 1'b0;
      model_data  <= '0;
    end else begin
      model_valid <= cntlr_rd && mem_en;
      model_data  <= mem[cntlr_raddr];
      if (cntlr_wr) mem[cntlr_waddr] <= cntlr_wr_data;
      else if (pre_we) mem[pre_addr] <= pre_data;
    end
  end
  assign cntlr_rd_valid = model_valid | late_valid;
  assign cntlr_rd_data  = model_valid ? model_data : 32'hBAD0_BAD0;

  // monitor
  int          rd_cnt = 0, wr_cnt = 0, resp_cnt = 0, both_cnt = 0;
  int          last_rd_cyc = 0, last_wr_cyc = 0, last_resp_cyc = 0;
  logic [10:0] last_waddr;
  logic [31:0] last_wdata, last_rdata;
  logic        last_err;
  logic [31:0] resp_q[$];
  logic [31:0] exp_q[$];

  always @(negedge clk) begin
    if (!rst) begin
      if (cntlr_rd) begin rd_cnt++; last_rd_cyc = cyc; end
      if (cntlr_wr) begin
        wr_cnt++; last_wr_cyc = cyc; last_waddr = cntlr_waddr; last_wdata = cntlr_wr_data;
      end
      if (cntlr_rd && cntlr_wr) both_cnt++;
      if (bus.resp_valid) begin
        resp_cnt++; last_resp_cyc = cyc; last_rdata = bus.resp_rdata; last_err = bus.resp_err;
        resp_q.push_back(bus.resp_rdata);
      end
    end
  end

  int n_cmp = 0, n_err = 0;
  int acc_cyc;

  // driver tasks
  task automatic mem_write(input logic [10:0] a, input logic [31:0] d);
    @(negedge clk);
    pre_addr = a; pre_data = d; pre_we = 1'b1;
    @(posedge clk); #1;
    pre_we = 1'b0;
  endtask

  task automatic issue(input logic we, input logic [10:0] a, input logic [31:0] d,
                       input logic [3:0] be);
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = we; bus.req_addr = a;
    bus.req_wdata = d; bus.req_be = be;
    acc_cyc = cyc;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_resp(input int r0, input string name);
    int n = 0;
    while (resp_cnt == r0 && n < 40) begin @(negedge clk); n++; end
    #1;
    if (resp_cnt == r0) begin
      n_cmp++; n_err++;
      $display("FAIL %s_resp_timeout got no resp_valid want one within 40 cycles", name);
    end
  endtask

  // scenarios
  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (bus.req_ready !== 1'b0) begin n_err++; $display("FAIL rst_ready got %b want 0", bus.req_ready); end
    n_cmp++; if (bus.resp_valid !== 1'b0) begin n_err++; $display("FAIL rst_resp_valid got %b want 0", bus.resp_valid); end
    n_cmp++; if ({cntlr_rd, cntlr_wr} !== 2'b00) begin n_err++; $display("FAIL rst_cntlr got %b want 00", {cntlr_rd, cntlr_wr}); end
    n_cmp++; if (cntlr_wr_data !== 32'h0 || bus.resp_rdata !== 32'h0) begin n_err++; $display("FAIL rst_data got %h/%h want 0/0", cntlr_wr_data, bus.resp_rdata); end
    rst = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if (bus.req_ready !== 1'b1) begin n_err++; $display("FAIL rst_release_ready got %b want 1", bus.req_ready); end
    n_cmp++; if (state_dbg !== 3'd0) begin n_err++; $display("FAIL rst_state got %0d want 0", state_dbg); end
  endtask

  task automatic test_load();
    int r0, rd0, wr0;
    mem_write(11'h010, 32'hDEAD_BEEF);
    r0 = resp_cnt; rd0 = rd_cnt; wr0 = wr_cnt;
    issue(1'b0, 11'h010, 32'h0, 4'hF);
    wait_resp(r0, "load");
    n_cmp++; if (last_rd_cyc - acc_cyc !== 1) begin n_err++; $display("FAIL load_rd_lat got %0d want 1", last_rd_cyc - acc_cyc); end
    n_cmp++; if (last_resp_cyc - acc_cyc !== 3) begin n_err++; $display("FAIL load_resp_lat got %0d want 3", last_resp_cyc - acc_cyc); end
    n_cmp++; if (last_rdata !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL load_rdata got %h want deadbeef", last_rdata); end
    n_cmp++; if (last_err !== 1'b0) begin n_err++; $display("FAIL load_err got %b want 0", last_err); end
    n_cmp++; if (rd_cnt - rd0 !== 1 || wr_cnt - wr0 !== 0) begin n_err++; $display("FAIL load_accesses got rd=%0d wr=%0d want 1/0", rd_cnt - rd0, wr_cnt - wr0); end
    @(negedge clk);
    n_cmp++; if (bus.resp_valid !== 1'b0 || bus.resp_rdata !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL load_hold got v=%b d=%h want 0/deadbeef", bus.resp_valid, bus.resp_rdata); end
  endtask

  task automatic test_full_store();
    int r0, rd0, wr0;
    r0 = resp_cnt; rd0 = rd_cnt; wr0 = wr_cnt;
    issue(1'b1, 11'h7FF, 32'h1234_5678, 4'hF);
    wait_resp(r0, "fstore");
    n_cmp++; if (wr_cnt - wr0 !== 1 || rd_cnt - rd0 !== 0) begin n_err++; $display("FAIL fstore_accesses got wr=%0d rd=%0d want 1/0", wr_cnt - wr0, rd_cnt - rd0); end
    n_cmp++; if (last_wr_cyc - acc_cyc !== 1) begin n_err++; $display("FAIL fstore_wr_lat got %0d want 1", last_wr_cyc - acc_cyc); end
    n_cmp++; if (last_waddr !== 11'h7FF || last_wdata !== 32'h1234_5678) begin n_err++; $display("FAIL fstore_wr got %h:%h want 7ff:12345678", last_waddr, last_wdata); end
    n_cmp++; if (last_resp_cyc - acc_cyc !== 2) begin n_err++; $display("FAIL fstore_resp_lat got %0d want 2", last_resp_cyc - acc_cyc); end
    n_cmp++; if (last_rdata !== 32'h0 || last_err !== 1'b0) begin n_err++; $display("FAIL fstore_resp got %h/%b want 0/0", last_rdata, last_err); end
  endtask

  task automatic test_partial_store();
    int r0, rd0, wr0;
    mem_write(11'h020, 32'hAABB_CCDD);
    r0 = resp_cnt; rd0 = rd_cnt; wr0 = wr_cnt;
    issue(1'b1, 11'h020, 32'h1122_3344, 4'b0101);
    wait_resp(r0, "pstore");
    n_cmp++; if (last_rd_cyc - acc_cyc !== 1) begin n_err++; $display("FAIL pstore_rd_lat got %0d want 1", last_rd_cyc - acc_cyc); end
    n_cmp++; if (last_wr_cyc - acc_cyc !== 3) begin n_err++; $display("FAIL pstore_wr_lat got %0d want 3", last_wr_cyc - acc_cyc); end
    n_cmp++; if (last_wdata !== 32'hAA22_CC44 || last_waddr !== 11'h020) begin n_err++; $display("FAIL pstore_merge got %h:%h want 020:aa22cc44", last_waddr, last_wdata); end
    n_cmp++; if (last_resp_cyc - acc_cyc !== 4) begin n_err++; $display("FAIL pstore_resp_lat got %0d want 4", last_resp_cyc - acc_cyc); end
    n_cmp++; if (rd_cnt - rd0 !== 1 || wr_cnt - wr0 !== 1) begin n_err++; $display("FAIL pstore_accesses got rd=%0d wr=%0d want 1/1", rd_cnt - rd0, wr_cnt - wr0); end
  endtask

  task automatic test_empty_store();
    int r0, rd0, wr0;
    r0 = resp_cnt; rd0 = rd_cnt; wr0 = wr_cnt;
    issue(1'b1, 11'h055, 32'hFFFF_FFFF, 4'h0);
    wait_resp(r0, "estore");
    n_cmp++; if (last_resp_cyc - acc_cyc !== 1) begin n_err++; $display("FAIL estore_resp_lat got %0d want 1", last_resp_cyc - acc_cyc); end
    n_cmp++; if (rd_cnt - rd0 !== 0 || wr_cnt - wr0 !== 0) begin n_err++; $display("FAIL estore_accesses got rd=%0d wr=%0d want 0/0", rd_cnt - rd0, wr_cnt - wr0); end
  endtask

  task automatic test_timeout();
    int r0, wr0;
    mem_en = 1'b0;
    r0 = resp_cnt; wr0 = wr_cnt;
    issue(1'b0, 11'h030, 32'h0, 4'hF);
    wait_resp(r0, "tmo");
    n_cmp++; if (last_resp_cyc - acc_cyc !== 10) begin n_err++; $display("FAIL tmo_resp_lat got %0d want 10", last_resp_cyc - acc_cyc); end
    n_cmp++; if (last_err !== 1'b1 || last_rdata !== 32'h0) begin n_err++; $display("FAIL tmo_resp got err=%b d=%h want 1/0", last_err, last_rdata); end
    n_cmp++; if (wr_cnt - wr0 !== 0) begin n_err++; $display("FAIL tmo_no_write got %0d want 0", wr_cnt - wr0); end
    @(negedge clk); late_valid = 1'b1;
    repeat (2) @(negedge clk);
    late_valid = 1'b0; mem_en = 1'b1;
    #1;
    n_cmp++; if (resp_cnt - r0 !== 1) begin n_err++; $display("FAIL tmo_late_ignored got %0d resps want 1", resp_cnt - r0); end
    n_cmp++; if (bus.req_ready !== 1'b1 || bus.resp_err !== 1'b1 || bus.resp_rdata !== 32'h0) begin n_err++; $display("FAIL tmo_late_state got rdy=%b err=%b d=%h want 1/1/0", bus.req_ready, bus.resp_err, bus.resp_rdata); end
  endtask

  task automatic test_reset_mid_write();
    int r0, wr0;
    r0 = resp_cnt; wr0 = wr_cnt;
    issue(1'b1, 11'h066, 32'hCAFE_F00D, 4'hF);
    n_cmp++; if (cntlr_wr !== 1'b1) begin n_err++; $display("FAIL mrst_in_wr got %b want 1", cntlr_wr); end
    rst = 1'b1;
    #1;
    n_cmp++; if ({cntlr_wr, cntlr_rd, bus.req_ready, bus.resp_valid} !== 4'b0000) begin n_err++; $display("FAIL mrst_outputs got %b want 0000", {cntlr_wr, cntlr_rd, bus.req_ready, bus.resp_valid}); end
    n_cmp++; if (cntlr_wr_data !== 32'h0) begin n_err++; $display("FAIL mrst_wdata got %h want 0", cntlr_wr_data); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if (bus.req_ready !== 1'b1) begin n_err++; $display("FAIL mrst_ready got %b want 1", bus.req_ready); end
    repeat (6) @(negedge clk);
    #1;
    n_cmp++; if (resp_cnt - r0 !== 0 || wr_cnt - wr0 !== 0) begin n_err++; $display("FAIL mrst_no_activity got resp=%0d wr=%0d want 0/0", resp_cnt - r0, wr_cnt - wr0); end
  endtask

  task automatic test_back_to_back();
    logic [10:0] addrs [4];
    logic [31:0] vals [4];
    int r0, rd0, n;
    addrs = '{11'h100, 11'h101, 11'h102, 11'h103};
    vals  = '{32'h1111_0001, 32'h2222_0002, 32'h3333_0003, 32'h4444_0004};
    for (int i = 0; i < 4; i++) begin
      mem_write(addrs[i], vals[i]);
      exp_q.push_back(vals[i]);
    end
    r0 = resp_cnt; rd0 = rd_cnt;
    resp_q.delete();
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_be = 4'hF; bus.req_wdata = '0;
    for (int i = 0; i < 4; i++) begin
      bus.req_addr = addrs[i];
      n = 0;
      while (bus.req_ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
      if (n >= 20) begin
        n_cmp++; n_err++;
        $display("FAIL b2b_accept_timeout got no req_ready want accept of req %0d", i);
      end
      @(posedge clk); #1;
      n_cmp++; if (bus.req_ready !== 1'b0) begin n_err++; $display("FAIL b2b_busy got %b want 0", bus.req_ready); end
      @(negedge clk);
    end
    bus.req_valid = 1'b0;
    n = 0;
    while (resp_cnt - r0 < 4 && n < 40) begin @(negedge clk); n++; end
    #1;
    n_cmp++; if (rd_cnt - rd0 !== 4 || resp_cnt - r0 !== 4) begin n_err++; $display("FAIL b2b_counts got rd=%0d resp=%0d want 4/4", rd_cnt - rd0, resp_cnt - r0); end
    for (int i = 0; i < 4; i++) begin
      logic [31:0] e, g;
      e = exp_q.pop_front();
      g = (i < resp_q.size()) ? resp_q[i] : 32'hXXXX_XXXX;
      n_cmp++; if (g !== e) begin n_err++; $display("FAIL b2b_data[%0d] got %h want %h", i, g, e); end
    end
  endtask

  initial begin
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_addr = '0;
    bus.req_wdata = '0; bus.req_be = '0;
    test_reset();
    test_load();
    test_full_store();
    test_partial_store();
    test_empty_store();
    test_timeout();
    test_reset_mid_write();
    test_back_to_back();
    n_cmp++; if (both_cnt !== 0) begin n_err++; $display("FAIL rd_wr_overlap got %0d want 0", both_cnt); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got no finish want finish before 200000");
    $fatal(1, "global time limit");
  end
endmodule
